usb_rx_engine: RTL and testbench

USB_RX_ENGINE -- requirements
Module: usb_rx_engine

---
 rtl/usb_rx_engine.sv | 193 +++++++++++++++++++
 tb/tb_usb_rx_engine.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/usb_rx_engine.sv
// rtl/usb_rx_engine.sv - USB receive engine: NRZI decode, destuff, PID/packet FSM, FIFO write side
// Ports:
//   clk, n_rst              clock, async active-low reset
//   dp, dm                  raw USB line pair (asynchronous)
//   rx_packet               last valid PID (0 none,1 OUT,2 IN,3 DATA0,4 DATA1,5 ACK,6 NAK,7 STALL)
//   rx_data_ready           pulse on error-free DATA packet end
//   rx_transfer_active      high while a packet is in progress
//   rx_error                sticky error for current/last packet
//   flush                   FIFO clear pulse at DATA PID
//   store_rx_packet_data    FIFO write strobe, rx_packet_data is the byte
//   buffer_occupancy        FIFO fill level
module usb_rx_engine #(
  parameter int CLKS_PER_BIT = 8,
  parameter int MAX_DATA     = 64,
  parameter int OCC_W        = 7
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic             dp,
  input  logic             dm,
  output logic [2:0]       rx_packet,
  output logic             rx_data_ready,
  output logic             rx_transfer_active,
  output logic             rx_error,
  output logic             flush,
  output logic             store_rx_packet_data,
  output logic [7:0]       rx_packet_data,
  input  logic [OCC_W-1:0] buffer_occupancy
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0]  HALF    = CW'(CLKS_PER_BIT / 2);
  localparam logic [CW-1:0]  LAST    = CW'(CLKS_PER_BIT - 1);
  localparam logic [OCC_W:0] MAX_LVL = (OCC_W + 1)'(MAX_DATA);

  typedef enum logic [2:0] {IDLE, SYNC, PID, TOKEN, DATA, EOP, ERR} state_t;

  logic dp_m, dp_s, dm_m, dm_s, dp_prev;
  logic [CW-1:0] cnt;
  logic sample, line_se0, line_j, line_k, nrzi_bit, full;
  logic [7:0] byte_next;

  state_t state_q, state_d;
  logic       last_dp_q, last_dp_d;
  logic [2:0] ones_q, ones_d, bitcnt_q, bitcnt_d;
  logic [7:0] shreg_q, shreg_d, hold0_q, hold0_d, hold1_q, hold1_d;
  logic [1:0] byte_cnt_q, byte_cnt_d;
  logic       se0_seen_q, se0_seen_d;
  logic       resync_q, resync_d;
  logic [2:0] pkt_q, pkt_d;
  logic       err_q, err_d, ready_q, ready_d, flush_q, flush_d, store_q, store_d;
  logic [7:0] data_q, data_d;

  // Synchronisers idle at J; bit clock re-centres on every dp edge.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      dp_m <= 1'b1; dp_s <= 1'b1; dp_prev <= 1'b1;
      dm_m <= 1'b0; dm_s <= 1'b0;
      cnt  <= '0;
    end else begin
      dp_m <= dp;  dp_s <= dp_m; dp_prev <= dp_s;
      dm_m <= dm;  dm_s <= dm_m;
      if (dp_s != dp_prev)  cnt <= CW'(1);
      else if (cnt == LAST) cnt <= '0;
      else                  cnt <= cnt + 1'b1;
    end
  end

  assign sample    = (dp_s == dp_prev) && (cnt == HALF);
  assign line_se0  = ~dp_s & ~dm_s;
  assign line_j    =  dp_s & ~dm_s;
  assign line_k    = ~dp_s &  dm_s;
  assign nrzi_bit  = (dp_s == last_dp_q);
  assign byte_next = {nrzi_bit, shreg_q[7:1]};
  assign full      = {1'b0, buffer_occupancy} >= MAX_LVL;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q <= IDLE; last_dp_q <= 1'b1; ones_q <= '0; bitcnt_q <= '0;
      shreg_q <= '0; hold0_q <= '0; hold1_q <= '0; byte_cnt_q <= '0;
      se0_seen_q <= 1'b0; resync_q <= 1'b1;
      pkt_q <= '0; err_q <= 1'b0; ready_q <= 1'b0; flush_q <= 1'b0;
      store_q <= 1'b0; data_q <= '0;
    end else begin
      state_q <= state_d; last_dp_q <= last_dp_d; ones_q <= ones_d; bitcnt_q <= bitcnt_d;
      shreg_q <= shreg_d; hold0_q <= hold0_d; hold1_q <= hold1_d; byte_cnt_q <= byte_cnt_d;
      se0_seen_q <= se0_seen_d; resync_q <= resync_d;
      pkt_q <= pkt_d; err_q <= err_d; ready_q <= ready_d; flush_q <= flush_d;
      store_q <= store_d; data_q <= data_d;
    end
  end

  always_comb begin
    state_d = state_q; last_dp_d = last_dp_q; ones_d = ones_q; bitcnt_d = bitcnt_q;
    shreg_d = shreg_q; hold0_d = hold0_q; hold1_d = hold1_q; byte_cnt_d = byte_cnt_q;
    se0_seen_d = se0_seen_q; resync_d = resync_q;
    pkt_d = pkt_q; err_d = err_q; ready_d = 1'b0; flush_d = 1'b0;
    store_d = 1'b0; data_d = data_q;
    if (sample) begin
      if (!line_se0) last_dp_d = dp_s;
      case (state_q)
        IDLE: begin
          if (resync_q) begin
            // After reset the line may be mid-packet: wait for an EOP first.
            if (line_se0) se0_seen_d = 1'b1;
            else if (line_j && se0_seen_q) begin
              resync_d = 1'b0; se0_seen_d = 1'b0;
            end
          end else if (line_k) begin
            // The first K is already the first (0) bit of SYNC.
            state_d = SYNC; bitcnt_d = 3'd1; shreg_d = {nrzi_bit, 7'd0};
            ones_d = '0; byte_cnt_d = '0; err_d = 1'b0; se0_seen_d = 1'b0;
          end
        end
        SYNC, PID, TOKEN, DATA: begin
          if (line_se0) begin
            se0_seen_d = 1'b1;
            if (state_q == DATA && bitcnt_q == 3'd0 && byte_cnt_q == 2'd2) state_d = EOP;
            else begin state_d = ERR; err_d = 1'b1; end
          end else if (ones_q == 3'd6) begin
            // Stuffed-bit slot: a 0 is dropped, a 1 is a stuff violation.
            ones_d = '0;
            if (nrzi_bit) begin state_d = ERR; err_d = 1'b1; end
          end else begin
            ones_d   = nrzi_bit ? ones_q + 3'd1 : 3'd0;
            shreg_d  = byte_next;
            bitcnt_d = bitcnt_q + 3'd1;
            if (bitcnt_q == 3'd7) begin
              case (state_q)
                SYNC: if (byte_next != 8'h80) begin state_d = ERR; err_d = 1'b1; end
                      else state_d = PID;
                PID: begin
                  byte_cnt_d = '0;
                  state_d = ERR; err_d = 1'b1;
                  if (byte_next[7:4] == ~byte_next[3:0]) begin
                    case (byte_next[3:0])
                      4'b0001: begin pkt_d = 3'd1; state_d = TOKEN; err_d = 1'b0; end
                      4'b1001: begin pkt_d = 3'd2; state_d = TOKEN; err_d = 1'b0; end
                      4'b0011: begin pkt_d = 3'd3; state_d = DATA; err_d = 1'b0; flush_d = 1'b1; end
                      4'b1011: begin pkt_d = 3'd4; state_d = DATA; err_d = 1'b0; flush_d = 1'b1; end
                      4'b0010: begin pkt_d = 3'd5; state_d = EOP;  err_d = 1'b0; end
                      4'b1010: begin pkt_d = 3'd6; state_d = EOP;  err_d = 1'b0; end
                      4'b1110: begin pkt_d = 3'd7; state_d = EOP;  err_d = 1'b0; end
                      default: ;
                    endcase
                  end
                end
                TOKEN: begin
                  byte_cnt_d = byte_cnt_q + 2'd1;
                  if (byte_cnt_q == 2'd1) state_d = EOP;
                end
                default: begin
                  // Two-byte delay line keeps the trailing CRC16 out of the FIFO.
                  byte_cnt_d = (byte_cnt_q == 2'd2) ? 2'd2 : byte_cnt_q + 2'd1;
                  hold0_d = byte_next;
                  hold1_d = hold0_q;
                  if (byte_cnt_q == 2'd2) begin
                    if (full) begin state_d = ERR; err_d = 1'b1; end
                    else begin store_d = 1'b1; data_d = hold1_q; end
                  end
                end
              endcase
            end
          end
        end
        EOP: begin
          if (line_se0) se0_seen_d = 1'b1;
          else if (se0_seen_q && line_j) begin
            state_d = IDLE; se0_seen_d = 1'b0;
            ready_d = (pkt_q == 3'd3 || pkt_q == 3'd4) && !err_q;
          end else begin
            state_d = ERR; err_d = 1'b1; se0_seen_d = 1'b0;
          end
        end
        default: begin
          if (line_se0) se0_seen_d = 1'b1;
          else if (se0_seen_q && line_j) begin
            state_d = IDLE; se0_seen_d = 1'b0;
          end
        end
      endcase
    end
  end

  assign rx_packet            = pkt_q;
  assign rx_data_ready        = ready_q;
  assign rx_transfer_active   = (state_q != IDLE);
  assign rx_error             = err_q;
  assign flush                = flush_q;
  assign store_rx_packet_data = store_q;
  assign rx_packet_data       = data_q;

endmodule

// File: tb/tb_usb_rx_engine.sv
// tb/tb_usb_rx_engine.sv - directed bench for usb_rx_engine
module tb_usb_rx_engine;
  localparam int CPB = 8;

  logic clk = 1'b0;
  logic n_rst, dp, dm;
  logic [2:0] rx_packet;
  logic rx_data_ready, rx_transfer_active, rx_error, flush, store_rx_packet_data;
  logic [7:0] rx_packet_data;
  logic [6:0] buffer_occupancy;

  usb_rx_engine #(.CLKS_PER_BIT(CPB), .MAX_DATA(64), .OCC_W(7)) dut (
    .clk(clk), .n_rst(n_rst), .dp(dp), .dm(dm),
    .rx_packet(rx_packet), .rx_data_ready(rx_data_ready),
    .rx_transfer_active(rx_transfer_active), .rx_error(rx_error),
    .flush(flush), .store_rx_packet_data(store_rx_packet_data),
    .rx_packet_data(rx_packet_data), .buffer_occupancy(buffer_occupancy)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int n_store = 0, n_flush = 0, n_ready = 0, n_both = 0;
  logic [7:0] stored[$];

  always @(negedge clk) begin
    if (store_rx_packet_data) begin n_store++; stored.push_back(rx_packet_data); end
    if (flush) n_flush++;
    if (rx_data_ready) n_ready++;
    if (store_rx_packet_data && flush) n_both++;
  end

  logic cur;
  int ones;
  bit bad_stuff;
  logic [7:0] pkt [0:7];
  int pkt_len;
  int s_st, s_fl, s_rd, s_bo;

  task automatic drive(input logic p, input logic m);
    dp = p; dm = m;
    repeat (CPB) @(negedge clk);
  endtask

  task automatic tx_bit(input logic b);
    if (!b) cur = ~cur;
    drive(cur, ~cur);
    if (b) ones++; else ones = 0;
    if (ones == 6) begin
      if (bad_stuff) bad_stuff = 1'b0;
      else cur = ~cur;
      drive(cur, ~cur);
      ones = 0;
    end
  endtask

  task automatic tx_byte(input logic [7:0] b);
    for (int i = 0; i < 8; i++) tx_bit(b[i]);
  endtask

  task automatic tx_eop();
    drive(1'b0, 1'b0); drive(1'b0, 1'b0);
    drive(1'b1, 1'b0); drive(1'b1, 1'b0);
    cur = 1'b1;
  endtask

  task automatic send_pkt();
    s_st = n_store; s_fl = n_flush; s_rd = n_ready; s_bo = n_both;
    cur = 1'b1; ones = 0;
    drive(1'b1, 1'b0);
    tx_byte(8'h80);
    for (int i = 0; i < pkt_len; i++) tx_byte(pkt[i]);
    tx_eop();
    drive(1'b1, 1'b0);
  endtask

  task automatic test_reset();
    n_rst = 1'b0; dp = 1'b1; dm = 1'b0; buffer_occupancy = '0; bad_stuff = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++; if (rx_packet !== 3'd0) begin n_bad++; $display("FAIL reset_pkt: got %0d want 0", rx_packet); end
    n_cmp++; if (rx_transfer_active !== 1'b0) begin n_bad++; $display("FAIL reset_active: got %b want 0", rx_transfer_active); end
    n_cmp++; if (rx_error !== 1'b0) begin n_bad++; $display("FAIL reset_err: got %b want 0", rx_error); end
    n_cmp++; if ({rx_data_ready, flush, store_rx_packet_data} !== 3'b000) begin n_bad++; $display("FAIL reset_pulses: got %b want 000", {rx_data_ready, flush, store_rx_packet_data}); end
    n_cmp++; if (rx_packet_data !== 8'h00) begin n_bad++; $display("FAIL reset_data: got %h want 00", rx_packet_data); end
    n_rst = 1'b1;
    tx_eop();
  endtask

  task automatic test_ack();
    pkt[0] = 8'hD2; pkt_len = 1;
    send_pkt();
    n_cmp++; if (rx_packet !== 3'd5) begin n_bad++; $display("FAIL ack_pkt: got %0d want 5", rx_packet); end
    n_cmp++; if (n_store - s_st != 0) begin n_bad++; $display("FAIL ack_stores: got %0d want 0", n_store - s_st); end
    n_cmp++; if (n_ready - s_rd != 0) begin n_bad++; $display("FAIL ack_ready: got %0d want 0", n_ready - s_rd); end
    n_cmp++; if (n_flush - s_fl != 0) begin n_bad++; $display("FAIL ack_flush: got %0d want 0", n_flush - s_fl); end
    n_cmp++; if (rx_error !== 1'b0) begin n_bad++; $display("FAIL ack_err: got %b want 0", rx_error); end
  endtask

  task automatic test_data0();
    logic [7:0] exp_b [0:2];
    exp_b[0] = 8'h01; exp_b[1] = 8'h02; exp_b[2] = 8'h03;
    pkt[0] = 8'hC3; pkt[1] = 8'h01; pkt[2] = 8'h02; pkt[3] = 8'h03; pkt[4] = 8'hA5; pkt[5] = 8'h5A; pkt_len = 6;
    send_pkt();
    n_cmp++; if (n_flush - s_fl != 1) begin n_bad++; $display("FAIL d0_flush: got %0d want 1", n_flush - s_fl); end
    n_cmp++; if (n_store - s_st != 3) begin n_bad++; $display("FAIL d0_stores: got %0d want 3", n_store - s_st); end
    for (int i = 0; i < 3; i++) begin
      n_cmp++;
      if (stored.size() <= s_st + i) begin n_bad++; $display("FAIL d0_byte%0d: got none want %h", i, exp_b[i]); end
      else if (stored[s_st + i] !== exp_b[i]) begin n_bad++; $display("FAIL d0_byte%0d: got %h want %h", i, stored[s_st + i], exp_b[i]); end
    end
    n_cmp++; if (rx_packet !== 3'd3) begin n_bad++; $display("FAIL d0_pkt: got %0d want 3", rx_packet); end
    n_cmp++; if (n_ready - s_rd != 1) begin n_bad++; $display("FAIL d0_ready: got %0d want 1", n_ready - s_rd); end
    n_cmp++; if (rx_error !== 1'b0) begin n_bad++; $display("FAIL d0_err: got %b want 0", rx_error); end
    n_cmp++; if (n_both - s_bo != 0) begin n_bad++; $display("FAIL d0_store_flush_overlap: got %0d want 0", n_both - s_bo); end
  endtask

  task automatic test_stuffing();
    pkt[0] = 8'h4B; pkt[1] = 8'h3F; pkt[2] = 8'hFF; pkt[3] = 8'h00; pkt[4] = 8'h00; pkt_len = 5;
    send_pkt();
    n_cmp++; if (n_store - s_st != 2) begin n_bad++; $display("FAIL d1_stores: got %0d want 2", n_store - s_st); end
    n_cmp++; if (stored.size() < s_st + 2 || stored[s_st] !== 8'h3F || stored[s_st + 1] !== 8'hFF) begin
      n_bad++; $display("FAIL d1_bytes: got %0d bytes want 3f ff", stored.size() - s_st); end
    n_cmp++; if (rx_packet !== 3'd4) begin n_bad++; $display("FAIL d1_pkt: got %0d want 4", rx_packet); end
    n_cmp++; if (n_ready - s_rd != 1) begin n_bad++; $display("FAIL d1_ready: got %0d want 1", n_ready - s_rd); end
    bad_stuff = 1'b1;
    send_pkt();
    n_cmp++; if (rx_error !== 1'b1) begin n_bad++; $display("FAIL stuff_err: got %b want 1", rx_error); end
    n_cmp++; if (n_ready - s_rd != 0) begin n_bad++; $display("FAIL stuff_ready: got %0d want 0", n_ready - s_rd); end
    n_cmp++; if (rx_transfer_active !== 1'b0) begin n_bad++; $display("FAIL stuff_active: got %b want 0", rx_transfer_active); end
  endtask

  task automatic test_bad_pid();
    pkt[0] = 8'hC2; pkt_len = 1;
    send_pkt();
    n_cmp++; if (rx_error !== 1'b1) begin n_bad++; $display("FAIL pid_err: got %b want 1", rx_error); end
    n_cmp++; if (rx_packet !== 3'd4) begin n_bad++; $display("FAIL pid_pkt: got %0d want 4", rx_packet); end
    n_cmp++; if (rx_transfer_active !== 1'b0) begin n_bad++; $display("FAIL pid_active: got %b want 0", rx_transfer_active); end
  endtask

  task automatic test_full();
    buffer_occupancy = 7'd64;
    pkt[0] = 8'hC3; pkt[1] = 8'h01; pkt[2] = 8'h02; pkt[3] = 8'h03; pkt[4] = 8'h00; pkt[5] = 8'h00; pkt_len = 6;
    send_pkt();
    buffer_occupancy = 7'd0;
    n_cmp++; if (n_store - s_st != 0) begin n_bad++; $display("FAIL full_stores: got %0d want 0", n_store - s_st); end
    n_cmp++; if (rx_error !== 1'b1) begin n_bad++; $display("FAIL full_err: got %b want 1", rx_error); end
    n_cmp++; if (n_ready - s_rd != 0) begin n_bad++; $display("FAIL full_ready: got %0d want 0", n_ready - s_rd); end
  endtask

  task automatic test_reset_mid_packet();
    cur = 1'b1; ones = 0;
    drive(1'b1, 1'b0);
    tx_byte(8'h80); tx_byte(8'hC3); tx_byte(8'h01); tx_byte(8'h02);
    n_cmp++; if (rx_transfer_active !== 1'b1) begin n_bad++; $display("FAIL mid_active: got %b want 1", rx_transfer_active); end
    n_rst = 1'b0;
    #1;
    n_cmp++; if ({rx_packet, rx_transfer_active, rx_error, rx_data_ready, flush, store_rx_packet_data} !== 8'h00) begin
      n_bad++; $display("FAIL mid_reset_outs: got %b want 0", {rx_packet, rx_transfer_active, rx_error, rx_data_ready, flush, store_rx_packet_data}); end
    n_cmp++; if (rx_packet_data !== 8'h00) begin n_bad++; $display("FAIL mid_reset_data: got %h want 00", rx_packet_data); end
    repeat (3) @(negedge clk);
    n_rst = 1'b1;
    s_st = n_store; s_rd = n_ready; s_fl = n_flush;
    tx_byte(8'h03); tx_byte(8'h00); tx_byte(8'h00);
    tx_eop();
    drive(1'b1, 1'b0);
    n_cmp++; if (n_store - s_st + n_ready - s_rd + n_flush - s_fl != 0) begin
      n_bad++; $display("FAIL mid_ignored: got %0d pulses want 0", n_store - s_st + n_ready - s_rd + n_flush - s_fl); end
    n_cmp++; if (rx_packet !== 3'd0) begin n_bad++; $display("FAIL mid_pkt: got %0d want 0", rx_packet); end
    pkt[0] = 8'hE1; pkt[1] = 8'h01; pkt[2] = 8'h80; pkt_len = 3;
    send_pkt();
    n_cmp++; if (rx_packet !== 3'd1) begin n_bad++; $display("FAIL out_pkt: got %0d want 1", rx_packet); end
    n_cmp++; if (rx_error !== 1'b0) begin n_bad++; $display("FAIL out_err: got %b want 0", rx_error); end
    n_cmp++; if (n_ready - s_rd != 0) begin n_bad++; $display("FAIL out_ready: got %0d want 0", n_ready - s_rd); end
  endtask

  initial begin
    test_reset();
    test_ack();
    test_data0();
    test_stuffing();
    test_bad_pid();
    test_full();
    test_reset_mid_packet();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
